// File: rtl/bus_fabric_if.sv
// Bus driver channels and contention status for bus_fabric.
// The fabric takes the slave view; the bus owner takes the master view.
interface bus_fabric_if #(
    parameter int WIDTH   = 8,
    parameter int DRIVERS = 6,
    parameter int CNT_W   = 8
);
    logic [DRIVERS*WIDTH-1:0] i_drvData;
    logic [DRIVERS-1:0]       i_drvNOe;
    logic                     i_clearErr;
    logic [WIDTH-1:0]         o_bus;
    logic                     o_busValid;
    logic                     o_contention;
    logic [DRIVERS-1:0]       o_contentionSrc;
    logic [CNT_W-1:0]         o_contentionCount;

    modport master (
        output i_drvData,
        output i_drvNOe,
        output i_clearErr,
        input  o_bus,
        input  o_busValid,
        input  o_contention,
        input  o_contentionSrc,
        input  o_contentionCount
    );

    modport slave (
        input  i_drvData,
        input  i_drvNOe,
        input  i_clearErr,
        output o_bus,
        output o_busValid,
        output o_contention,
        output o_contentionSrc,
        output o_contentionCount
    );
endinterface

// File: rtl/bus_fabric.sv
// Wired-OR shared bus with keeper and contention tracking,
// plus a halt/run/single-step controller driving a core clock enable.
module bus_fabric #(
    parameter int WIDTH              = 8,
    parameter int DRIVERS            = 6,
    parameter int CNT_W              = 8,
    parameter bit HALT_ON_CONTENTION = 1'b1,
    parameter bit RESET_HALTED       = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_nReset,
    bus_fabric_if.slave bus,
    input  logic        i_ctrlHlt,
    input  logic        i_button,
    input  logic        i_stepMode,
    output logic        o_clkEn,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam state_t RST_STATE = RESET_HALTED ? S_HALT : S_RUN;
    localparam logic [DRIVERS-1:0] EN_ONE = {{(DRIVERS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DRIVERS-1:0] en;
    logic               any_en;
    logic               multi_en;
    logic               one_en;
    logic [WIDTH-1:0]   or_bus;
    logic               event_w;
    logic               press;

    logic [WIDTH-1:0]   keeper_q, keeper_d;
    logic               cont_q, cont_d;
    logic [DRIVERS-1:0] src_q, src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sync0_q, sync1_q, prev_q;
    state_t             state_q, state_d;

    // Active set; clearing the lowest set bit leaves something iff 2+ drivers.
    assign en       = ~bus.i_drvNOe;
    assign any_en   = |en;
    assign multi_en = |(en & (en - EN_ONE));
    assign one_en   = any_en & ~multi_en;

    // Wired-OR of every enabled channel.
    always_comb begin
        or_bus = '0;
        for (int k = 0; k < DRIVERS; k++) begin
            if (en[k]) begin
                or_bus = or_bus | bus.i_drvData[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.o_bus             = any_en ? or_bus : keeper_q;
    assign bus.o_busValid        = one_en;
    assign bus.o_contention      = cont_q;
    assign bus.o_contentionSrc   = src_q;
    assign bus.o_contentionCount = cnt_q;

    // Contention only counts while the core is actually clocked.
    assign event_w = multi_en & o_clkEn;
    assign press   = sync1_q & ~prev_q;

    // Keeper and contention status; a new event beats a same-edge clear.
    always_comb begin
        keeper_d = one_en ? or_bus : keeper_q;
        cont_d   = cont_q;
        src_d    = src_q;
        cnt_d    = cnt_q;
        if (event_w) begin
            cont_d = 1'b1;
            if (!cont_q || bus.i_clearErr) begin
                src_d = en;
            end
            if (bus.i_clearErr) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (bus.i_clearErr) begin
            cont_d = 1'b0;
            src_d  = '0;
            cnt_d  = '0;
        end
    end

    // Keeper and contention status registers.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            keeper_q <= '0;
            cont_q   <= 1'b0;
            src_q    <= '0;
            cnt_q    <= '0;
        end else begin
            keeper_q <= keeper_d;
            cont_q   <= cont_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
        end
    end

    // Two-flop button synchronizer plus edge-detect history.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync0_q <= i_button;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
        end
    end

    // Run-control next state; RUN priority is halt, contention, step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (i_ctrlHlt) begin
                    state_d = S_HALT;
                end else if (HALT_ON_CONTENTION && event_w) begin
                    state_d = S_HALT;
                end else if (i_stepMode) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (press) begin
                    state_d = i_stepMode ? S_STEP : S_RUN;
                end
            end
            S_STEP:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Run-control state register.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_clkEn = (state_q != S_HALT);
    assign o_state = state_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed scenarios on two
// parameter sets, then random stimulus against a behavioural model.
module tb_bus_fabric;

    typedef struct packed {
        logic [7:0]  keeper;
        logic        cont;
        logic [5:0]  src;
        logic [31:0] cnt;
        logic [1:0]  st;
        logic        s0;
        logic        s1;
        logic        pv;
    } model_t;

    logic        clk = 1'b0;
    logic        nReset;
    logic [47:0] drvData;
    logic [5:0]  drvNOe;
    logic        clearErr;
    logic        ctrlHlt;
    logic        button;
    logic        stepMode;
    logic        clkEnA, clkEnB;
    logic [1:0]  stateA, stateB;

    int nChecks = 0;
    int nFail = 0;
    model_t mA, mB;

    bus_fabric_if #(.WIDTH(8), .DRIVERS(6), .CNT_W(2)) ifA ();
    bus_fabric_if #(.WIDTH(8), .DRIVERS(6), .CNT_W(8)) ifB ();

    assign ifA.i_drvData  = drvData;
    assign ifA.i_drvNOe   = drvNOe;
    assign ifA.i_clearErr = clearErr;
    assign ifB.i_drvData  = drvData;
    assign ifB.i_drvNOe   = drvNOe;
    assign ifB.i_clearErr = clearErr;

    bus_fabric #(
        .WIDTH(8), .DRIVERS(6), .CNT_W(2),
        .HALT_ON_CONTENTION(1'b0), .RESET_HALTED(1'b0)
    ) dutA (
        .i_clk(clk), .i_nReset(nReset), .bus(ifA),
        .i_ctrlHlt(ctrlHlt), .i_button(button),
        .i_stepMode(stepMode), .o_clkEn(clkEnA), .o_state(stateA)
    );

    bus_fabric #(
        .WIDTH(8), .DRIVERS(6), .CNT_W(8),
        .HALT_ON_CONTENTION(1'b1), .RESET_HALTED(1'b1)
    ) dutB (
        .i_clk(clk), .i_nReset(nReset), .bus(ifB),
        .i_ctrlHlt(ctrlHlt), .i_button(button),
        .i_stepMode(stepMode), .o_clkEn(clkEnB), .o_state(stateB)
    );

    always #5 clk = ~clk;

    function automatic int n_en(logic [5:0] noe);
        int c;
        c = 0;
        for (int k = 0; k < 6; k++) if (!noe[k]) c++;
        return c;
    endfunction

    function automatic logic [7:0] or_of(logic [5:0] noe, logic [47:0] d);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) if (!noe[k]) r = r | d[k*8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] model_bus(model_t m);
        return (n_en(drvNOe) > 0) ? or_of(drvNOe, drvData) : m.keeper;
    endfunction

    function automatic model_t model_reset(bit rh);
        model_t m;
        m = '0;
        m.st = rh ? 2'd1 : 2'd0;
        return m;
    endfunction

    // One rising edge of the reference, from the rules in plain terms.
    function automatic model_t model_step(model_t m, int cmax, bit hoc);
        model_t n;
        int     k;
        bit     ev;
        bit     pr;
        n  = m;
        k  = n_en(drvNOe);
        ev = (k >= 2) && (m.st != 2'd1);
        pr = m.s1 && !m.pv;
        if (k == 1) n.keeper = or_of(drvNOe, drvData);
        if (ev) begin
            n.cont = 1'b1;
            if (!m.cont || clearErr) n.src = ~drvNOe;
            if (clearErr) n.cnt = 1;
            else n.cnt = (int'(m.cnt) < cmax) ? m.cnt + 1 : cmax;
        end else if (clearErr) begin
            n.cont = 1'b0;
            n.src  = '0;
            n.cnt  = 0;
        end
        n.s0 = button;
        n.s1 = m.s0;
        n.pv = m.s1;
        case (m.st)
            2'd0: n.st = (ctrlHlt || (ev && hoc) || stepMode) ? 2'd1 : 2'd0;
            2'd1: if (pr) n.st = stepMode ? 2'd2 : 2'd0;
            default: n.st = 2'd1;
        endcase
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (nReset) begin
            mA = model_step(mA, 3, 1'b0);
            mB = model_step(mB, 255, 1'b1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drvNOe = '1; drvData = '0; clearErr = 0;
        ctrlHlt = 0; button = 0; stepMode = 0;
        nReset = 1'b1;
        #1 nReset = 1'b0;
        mA = model_reset(1'b0);
        mB = model_reset(1'b1);
        #2;
        nChecks++;
        if ({stateA, clkEnA} !== {2'd0, 1'b1}) begin
            nFail++;
            $display("FAIL reset_runA state/clkEn got %h exp %h", {stateA, clkEnA}, 3'b001);
        end
        nChecks++;
        if ({ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount} !== 9'd0) begin
            nFail++;
            $display("FAIL reset_statusA got %b exp 0", {ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount});
        end
        nChecks++;
        if ({ifA.o_bus, ifA.o_busValid} !== 9'd0) begin
            nFail++;
            $display("FAIL reset_busA got %h exp 0", {ifA.o_bus, ifA.o_busValid});
        end
        nChecks++;
        if ({stateB, clkEnB} !== {2'd1, 1'b0}) begin
            nFail++;
            $display("FAIL reset_haltedB state/clkEn got %h exp %h", {stateB, clkEnB}, 3'b010);
        end
        tick();
        nReset = 1'b1;
        tick();
        nChecks++;
        if (stateA !== 2'd0 || stateB !== 2'd1) begin
            nFail++;
            $display("FAIL reset_release got A=%0d B=%0d exp A=0 B=1", stateA, stateB);
        end
    endtask

    task automatic test_single_driver();
        drvData = 48'({$urandom(), $urandom()});
        drvData[2*8 +: 8] = 8'h5A;
        drvNOe = ~6'b000100;
        #1;
        nChecks++;
        if ({ifA.o_bus, ifA.o_busValid} !== {8'h5A, 1'b1}) begin
            nFail++;
            $display("FAIL single_drive got %h/%b exp 5a/1", ifA.o_bus, ifA.o_busValid);
        end
        tick();
        drvNOe = '1;
        drvData = 48'({$urandom(), $urandom()});
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if ({ifA.o_bus, ifA.o_busValid, ifB.o_bus} !== {8'h5A, 1'b0, 8'h5A}) begin
                nFail++;
                $display("FAIL keeper_hold[%0d] got A=%h/%b B=%h exp 5a/0 5a", i, ifA.o_bus, ifA.o_busValid, ifB.o_bus);
            end
        end
    endtask

    task automatic test_contention();
        drvData = 48'({$urandom(), $urandom()});
        drvData[1*8 +: 8] = 8'h0F;
        drvData[4*8 +: 8] = 8'h30;
        drvNOe = ~6'b010010;
        #1;
        nChecks++;
        if (ifA.o_bus !== 8'h3F || ifA.o_busValid !== 1'b0) begin
            nFail++;
            $display("FAIL cont_bus got %h/%b exp 3f/0", ifA.o_bus, ifA.o_busValid);
        end
        tick();
        tick();
        nChecks++;
        if ({ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount, stateA} !== {1'b1, 6'b010010, 2'd2, 2'd0}) begin
            nFail++;
            $display("FAIL cont_status got %b/%b/%0d/%0d exp 1/010010/2/0", ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount, stateA);
        end
        nChecks++;
        if (ifB.o_contention !== 1'b0 || ifB.o_contentionCount !== 8'd0) begin
            nFail++;
            $display("FAIL cont_halted_ignored got %b/%0d exp 0/0", ifB.o_contention, ifB.o_contentionCount);
        end
        drvNOe = ~6'b100001;
        clearErr = 1;
        tick();
        clearErr = 0;
        drvNOe = '1;
        nChecks++;
        if ({ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount} !== {1'b1, 6'b100001, 2'd1}) begin
            nFail++;
            $display("FAIL clear_vs_event got %b/%b/%0d exp 1/100001/1", ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount);
        end
        clearErr = 1;
        tick();
        clearErr = 0;
        nChecks++;
        if ({ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount} !== 9'd0) begin
            nFail++;
            $display("FAIL clear_only got %b/%b/%0d exp 0/0/0", ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount);
        end
    endtask

    task automatic test_halt_resume();
        ctrlHlt = 1;
        #1;
        nChecks++;
        if (clkEnA !== 1'b1) begin
            nFail++;
            $display("FAIL halt_cycle_completes clkEn got %b exp 1", clkEnA);
        end
        tick();
        ctrlHlt = 0;
        nChecks++;
        if ({stateA, clkEnA} !== {2'd1, 1'b0}) begin
            nFail++;
            $display("FAIL halt_entry got %0d/%b exp 1/0", stateA, clkEnA);
        end
        button = 1;
        for (int j = 0; j < 3; j++) begin
            tick();
            nChecks++;
            if (stateA !== ((j == 2) ? 2'd0 : 2'd1)) begin
                nFail++;
                $display("FAIL resume_edge[k+%0d] state got %0d exp %0d", j, stateA, (j == 2) ? 0 : 1);
            end
        end
        button = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_single_step();
        int hiA, hiB;
        hiA = 0;
        hiB = 0;
        stepMode = 1;
        tick();
        nChecks++;
        if (stateA !== 2'd1 || stateB !== 2'd1) begin
            nFail++;
            $display("FAIL step_mode_halt got A=%0d B=%0d exp 1/1", stateA, stateB);
        end
        for (int p = 0; p < 3; p++) begin
            button = 1;
            for (int j = 0; j < 6; j++) begin
                tick();
                hiA += int'(clkEnA);
                hiB += int'(clkEnB);
                nChecks++;
                if (stateA !== ((j == 2) ? 2'd2 : 2'd1)) begin
                    nFail++;
                    $display("FAIL step[%0d] edge k+%0d state got %0d exp %0d", p, j, stateA, (j == 2) ? 2 : 1);
                end
                if (j == 2) button = 0;
            end
        end
        nChecks++;
        if (hiA != 3 || hiB != 3) begin
            nFail++;
            $display("FAIL step_pulses got A=%0d B=%0d exp 3/3", hiA, hiB);
        end
    endtask

    task automatic test_saturation();
        stepMode = 0;
        button = 1;
        tick(); tick(); tick();
        button = 0;
        nChecks++;
        if (stateA !== 2'd0 || stateB !== 2'd0) begin
            nFail++;
            $display("FAIL sat_resume got A=%0d B=%0d exp 0/0", stateA, stateB);
        end
        clearErr = 1;
        tick();
        clearErr = 0;
        drvData = 48'({$urandom(), $urandom()});
        drvNOe = ~6'b000011;
        tick();
        nChecks++;
        if ({stateB, ifB.o_contention, ifB.o_contentionCount} !== {2'd1, 1'b1, 8'd1}) begin
            nFail++;
            $display("FAIL halt_on_contention got %0d/%b/%0d exp 1/1/1", stateB, ifB.o_contention, ifB.o_contentionCount);
        end
        tick(); tick(); tick(); tick();
        nChecks++;
        if ({ifA.o_contention, ifA.o_contentionCount, stateA} !== {1'b1, 2'd3, 2'd0}) begin
            nFail++;
            $display("FAIL saturate got %b/%0d/%0d exp 1/3/0", ifA.o_contention, ifA.o_contentionCount, stateA);
        end
        nChecks++;
        if (ifB.o_contentionCount !== 8'd1) begin
            nFail++;
            $display("FAIL halted_count_frozen got %0d exp 1", ifB.o_contentionCount);
        end
        drvNOe = '1;
        ctrlHlt = 1;
        tick();
        ctrlHlt = 0;
        clearErr = 1;
        tick();
        clearErr = 0;
        drvNOe = ~6'b101000;
        tick(); tick(); tick();
        drvNOe = '1;
        nChecks++;
        if ({stateA, ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount} !== {2'd1, 1'b0, 6'd0, 2'd0}) begin
            nFail++;
            $display("FAIL halt_gates_contention got %0d/%b/%b/%0d exp 1/0/0/0", stateA, ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount);
        end
    endtask

    task automatic test_reset_mid_step();
        stepMode = 0;
        button = 1;
        tick(); tick(); tick();
        button = 0;
        drvNOe = ~6'b110000;
        tick();
        drvNOe = '1;
        stepMode = 1;
        tick();
        tick();
        button = 1;
        tick(); tick(); tick();
        nChecks++;
        if ({stateA, ifA.o_contention, ifA.o_bus} !== {2'd2, 1'b1, 8'h5A}) begin
            nFail++;
            $display("FAIL pre_reset got %0d/%b/%h exp 2/1/5a", stateA, ifA.o_contention, ifA.o_bus);
        end
        #2 nReset = 0;
        mA = model_reset(1'b0);
        mB = model_reset(1'b1);
        #1;
        nChecks++;
        if ({stateA, clkEnA, ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount, ifA.o_bus} !== {2'd0, 1'b1, 1'b0, 6'd0, 2'd0, 8'h00}) begin
            nFail++;
            $display("FAIL async_reset_A got %0d/%b/%b/%b/%0d/%h exp 0/1/0/0/0/00", stateA, clkEnA, ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount, ifA.o_bus);
        end
        nChecks++;
        if ({stateB, clkEnB, ifB.o_contention, ifB.o_contentionCount} !== {2'd1, 1'b0, 1'b0, 8'd0}) begin
            nFail++;
            $display("FAIL async_reset_B got %0d/%b/%b/%0d exp 1/0/0/0", stateB, clkEnB, ifB.o_contention, ifB.o_contentionCount);
        end
        button = 0;
        stepMode = 0;
        @(negedge clk);
        nReset = 1;
    endtask

    task automatic test_random();
        logic [20:0] gotA, expA;
        logic [26:0] gotB, expB;
        int r;
        for (int i = 0; i < 800; i++) begin
            drvData = 48'({$urandom(), $urandom()});
            r = $urandom_range(0, 3);
            if (r == 0) drvNOe = '1;
            else if (r == 1) drvNOe = ~(6'b000001 << $urandom_range(0, 5));
            else drvNOe = 6'($urandom());
            clearErr = ($urandom_range(0, 15) == 0);
            ctrlHlt = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) button = ~button;
            if ($urandom_range(0, 19) == 0) stepMode = ~stepMode;
            #1;
            gotA = {ifA.o_bus, ifA.o_busValid, ifA.o_contention, ifA.o_contentionSrc, ifA.o_contentionCount, stateA, clkEnA};
            expA = {model_bus(mA), n_en(drvNOe) == 1, mA.cont, mA.src, mA.cnt[1:0], mA.st, mA.st != 2'd1};
            gotB = {ifB.o_bus, ifB.o_busValid, ifB.o_contention, ifB.o_contentionSrc, ifB.o_contentionCount, stateB, clkEnB};
            expB = {model_bus(mB), n_en(drvNOe) == 1, mB.cont, mB.src, mB.cnt[7:0], mB.st, mB.st != 2'd1};
            nChecks++;
            if (gotA !== expA) begin
                nFail++;
                $display("FAIL random_A cycle %0d got %h exp %h", i, gotA, expA);
            end
            nChecks++;
            if (gotB !== expB) begin
                nFail++;
                $display("FAIL random_B cycle %0d got %h exp %h", i, gotB, expB);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_driver();
        test_contention();
        test_halt_resume();
        test_single_step();
        test_saturation();
        test_reset_mid_step();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
Parametrised shared-bus and run-control block for the next-generation CPU datapath. It replaces hand-wired multi-driver bus assignment with explicit wired-OR resolution over N tri-state-style drivers. It adds a bus keeper and contention detection with a sticky error report. It also provides a synchronous halt/run/single-step controller that issues a clock-enable to the core instead of gating the clock.

Parameters:
WIDTH, 8, bus data width in bits
DRIVERS, 6, number of bus driver channels
CNT_W, 8, width of saturating contention counter
HALT_ON_CONTENTION, 1, 1 = a contention event forces HALT
RESET_HALTED, 0, 1 = leave reset in HALT instead of RUN

Ports:
i_clk  in  1  system clock; all state on rising edge
i_nReset  in  1  asynchronous, active-low reset
i_drvData  in  DRIVERS*WIDTH  driver data; channel k at bits [k*WIDTH +: WIDTH]
i_drvNOe  in  DRIVERS  active-low output enable per channel
o_bus  out  WIDTH  resolved bus value (combinational)
o_busValid  out  1  exactly one driver enabled this cycle
o_contention  out  1  sticky: two or more drivers were enabled at an enabled edge
o_contentionSrc  out  DRIVERS  enable mask captured at first contention since clear
o_contentionCount  out  CNT_W  saturating count of contention edges
i_clearErr  in  1  synchronous clear of contention status and counter
i_ctrlHlt  in  1  halt request from control unit
i_button  in  1  asynchronous resume/step push button
i_stepMode  in  1  1 = single-step operation
o_clkEn  out  1  core clock enable
o_state  out  2  0 RUN, 1 HALT, 2 STEP

Behaviour:
- Active set: en = ~i_drvNOe. Active count = popcount(en).
- Bus resolution, count >= 1: o_bus = bitwise OR of i_drvData over enabled channels.
- Bus resolution, count = 0: o_bus = keeper register.
- o_busValid = (count == 1).
- Keeper: on every edge where count == 1, load the resolved value, regardless of o_clkEn. Otherwise hold. Reset value 0.
- Contention event: an edge with count >= 2 and o_clkEn = 1. Contention while o_clkEn = 0 is ignored, since the core is frozen.
- On a contention event:
  - o_contention is set to 1.
  - o_contentionSrc is loaded only if o_contention was 0 before the edge (first-event capture).
  - o_contentionCount increments and saturates at 2^CNT_W-1.
- i_clearErr at an edge clears o_contention, o_contentionSrc and the counter.
- Clear and contention at the same edge: the new event wins. Result is contention = 1, src = current mask, count = 1.
- Button synchronizer: sync0 <- i_button, then sync1 <- sync0, then prev <- sync1. Press = sync1 & ~prev.
  - i_button rising before edge k gives press high during the cycle after edge k+1.
  - The resulting state change takes effect at edge k+2.
- FSM, registered state, o_clkEn = (state != HALT) as a combinational decode:
  - RUN:
    - i_ctrlHlt = 1 -> HALT. The halting instruction's cycle completes; o_clkEn is low from the next cycle.
    - Else a contention event with HALT_ON_CONTENTION = 1 -> HALT.
    - Else i_stepMode = 1 -> HALT.
    - Otherwise stay in RUN.
  - HALT:
    - press with i_stepMode = 1 -> STEP.
    - press with i_stepMode = 0 -> RUN.
    - i_ctrlHlt is ignored.
  - STEP:
    - Exactly one cycle with o_clkEn = 1, then unconditionally -> HALT.
    - press and i_ctrlHlt are ignored.
  - Encoding 3 is unreachable; if entered, recover to HALT.
- Priority in RUN: halt over contention over stepMode. A simultaneous press is ignored in RUN.
- Reset (asynchronous, any time including mid-STEP):
  - state = HALT if RESET_HALTED, else RUN.
  - Keeper, contention flag, src, counter and synchronizer flops all cleared.
  - o_clkEn follows the reset state immediately.

Test Plan:
- Single driver: WIDTH=8, channel 2 enabled with data 0x5A -> o_bus = 0x5A, o_busValid = 1. Then all disabled for 3 cycles -> o_bus stays 0x5A, o_busValid = 0.
- Contention: channels 1 (0x0F) and 4 (0x30) enabled for 2 edges in RUN with HALT_ON_CONTENTION = 0.
  - Required: o_bus = 0x3F, o_contention = 1, o_contentionSrc = 6'b010010, count = 2.
  - Then i_clearErr together with channels 0 and 5 enabled -> src = 6'b100001, count = 1.
- Halt then resume: i_ctrlHlt pulsed for 1 cycle in RUN -> o_state = 1 and o_clkEn = 0 from the next cycle. Button raised before edge k with stepMode = 0 -> o_state = 0 after edge k+2.
- Single step: stepMode = 1 in HALT, three separate button presses -> exactly three isolated single-cycle o_clkEn pulses, with o_state returning to 1 after each.
- Counter saturation and clkEn gating, CNT_W = 2:
  - 5 contention edges -> count = 3.
  - Contention while in HALT -> no change to flag or count.
- Reset mid-STEP: i_nReset low asynchronously during STEP -> o_state = 0 and all status outputs cleared without waiting for a clock edge. With RESET_HALTED = 1 -> o_state = 1 and o_clkEn = 0.
